// File: rtl/dice_cta_dispatcher.sv
// CTA dispatcher: walks a kernel grid and issues credit-throttled CTA descriptors.
// Optional stall counter with `define DICE_CTA_DISPATCH_PERF_EN.
`ifndef DICE_NUM_MAX_CTA_PER_CORE
`define DICE_NUM_MAX_CTA_PER_CORE 4
`endif

package dice_pkg;
  localparam int DICE_CTA_ID_WIDTH = 8;
  localparam int IW = DICE_CTA_ID_WIDTH;

  typedef struct packed {
    logic [IW:0]   grid_z;
    logic [IW:0]   grid_y;
    logic [IW:0]   grid_x;
    logic [31:0]   param_base;
    logic [31:0]   kernel_pc;
  } dice_kernel_desc_t;

  typedef struct packed {
    logic [IW-1:0] z;
    logic [IW-1:0] y;
    logic [IW-1:0] x;
  } dice_cta_id_t;

  typedef struct packed {
    dice_kernel_desc_t kernel_desc;
    dice_cta_id_t      cta_id;
  } dice_cta_desc_t;
endpackage

module dice_cta_dispatcher
  import dice_pkg::*;
#(
  parameter int MAX_OUTSTANDING = `DICE_NUM_MAX_CTA_PER_CORE,
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              kdesc_valid,
  output logic              kdesc_ready,
  input  dice_kernel_desc_t kdesc,
  output logic              cta_valid,
  input  logic              cta_ready,
  output dice_cta_desc_t    cta_desc,
  input  logic              cta_retire,
  output logic              kernel_busy,
  output logic              kernel_done
`ifdef DICE_CTA_DISPATCH_PERF_EN
  ,
  output logic [31:0]       perf_stall_cyc
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTSTANDING);
  localparam logic [IW:0]      ONE   = (IW+1)'(1);

  logic [1:0]        r_state;
  dice_kernel_desc_t r_kd;
  dice_cta_id_t      r_id;
  logic [CNT_W-1:0]  r_out;

  logic w_credit;
  logic w_hs;
  logic w_ret;
  logic w_xl;
  logic w_yl;
  logic w_zl;
  logic w_zero;

  assign w_credit = (r_out < MAX_C);
  assign w_hs     = cta_valid && cta_ready;
  // Retires are only meaningful once a launch is in flight
  assign w_ret    = cta_retire && (r_state != S_IDLE)
                 && (r_out != '0);

  assign w_xl = ({1'b0, r_id.x} == r_kd.grid_x - ONE);
  assign w_yl = ({1'b0, r_id.y} == r_kd.grid_y - ONE);
  assign w_zl = ({1'b0, r_id.z} == r_kd.grid_z - ONE);

  assign w_zero = (kdesc.grid_x == '0)
               || (kdesc.grid_y == '0)
               || (kdesc.grid_z == '0);

  assign kdesc_ready = (r_state == S_IDLE);
  assign kernel_busy = (r_state != S_IDLE);
  assign kernel_done = (r_state == S_DONE);
  assign cta_valid   = (r_state == S_ISSUE) && w_credit;
  assign cta_desc    = '{kernel_desc: r_kd, cta_id: r_id};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_kd    <= '0;
      r_id    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (kdesc_valid) begin
            r_kd    <= kdesc;
            r_id    <= '0;
            r_state <= w_zero ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_hs) begin
            if (w_xl && w_yl && w_zl) begin
              r_state <= S_DRAIN;
            end else if (w_xl) begin
              r_id.x <= '0;
              if (w_yl) begin
                r_id.y <= '0;
                r_id.z <= r_id.z + 1'b1;
              end else begin
                r_id.y <= r_id.y + 1'b1;
              end
            end else begin
              r_id.x <= r_id.x + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (r_out == '0) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out <= '0;
    end else if (w_hs && !w_ret) begin
      r_out <= r_out + 1'b1;
    end else if (w_ret && !w_hs) begin
      r_out <= r_out - 1'b1;
    end
  end

`ifdef DICE_CTA_DISPATCH_PERF_EN
  logic [31:0] r_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall <= '0;
    end else if ((r_state == S_ISSUE)
              && ((cta_valid && !cta_ready) || !w_credit)) begin
      r_stall <= r_stall + 32'd1;
    end
  end

  assign perf_stall_cyc = r_stall;
`endif

endmodule
